// File: rtl/f11_svc_pkg.sv
// Shared types and constants for the F11 service word and interrupt arbiter.
package f11_svc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } svc_state_e;

   // Service word bit positions; [15:13] and [6] are always zero
   localparam int unsigned SVC_EVNT  = 12;
   localparam int unsigned SVC_IRQ4  = 11;
   localparam int unsigned SVC_IRQ5  = 10;
   localparam int unsigned SVC_IRQ6  = 9;
   localparam int unsigned SVC_IRQ7  = 8;
   localparam int unsigned SVC_ACLO  = 7;
   localparam int unsigned SVC_HALT  = 5;
   localparam int unsigned SVC_CCERR = 4;
   localparam int unsigned SVC_MMU   = 3;
   localparam int unsigned SVC_PAR   = 2;
   localparam int unsigned SVC_BTO   = 1;
   localparam int unsigned SVC_DCLO  = 0;

   localparam logic [2:0] LVL_IRQ4 = 3'd4;
   localparam logic [2:0] LVL_IRQ5 = 3'd5;
   localparam logic [2:0] LVL_IRQ6 = 3'd6;
   localparam logic [2:0] LVL_IRQ7 = 3'd7;

   // One-hot winner: highest requesting level strictly above the CPU priority
   function automatic logic [3:0] pick_winner(input logic [3:0] req, input logic [2:0] pri);
      logic [3:0] g;
      g = 4'b0000;
      if (req[3] && (LVL_IRQ7 > pri))      g = 4'b1000;
      else if (req[2] && (LVL_IRQ6 > pri)) g = 4'b0100;
      else if (req[1] && (LVL_IRQ5 > pri)) g = 4'b0010;
      else if (req[0] && (LVL_IRQ4 > pri)) g = 4'b0001;
      return g;
   endfunction

endpackage

// File: rtl/f11_svc_sync.sv
// Multi-flop synchronizer for a group of asynchronous level inputs.
module f11_svc_sync #(
   parameter int unsigned W       = 1,
   parameter int unsigned STG     = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stg_q [STG];

   // Shift chain; resets to the inactive level of the group
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STG); i++) stg_q[i] <= {W{RST_VAL}};
      end else begin
         stg_q[0] <= d_i;
         for (int i = 1; i < int'(STG); i++) stg_q[i] <= stg_q[i-1];
      end
   end

   assign q_o = stg_q[STG-1];

endmodule

// File: rtl/f11_svc_arb.sv
// F11 service word builder and vectored interrupt acknowledge arbiter.
module f11_svc_arb
   import f11_svc_pkg::*;
#(
   parameter int unsigned TMO_CYC  = 64,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic        pin_clk,
   input  logic        pin_rst_n,
   input  logic [3:0]  irq,
   input  logic        evnt,
   input  logic        aclo_n,
   input  logic        halt,
   input  logic        ccerr_n,
   input  logic        mmu_n,
   input  logic        par_n,
   input  logic        dclo_n,
   input  logic        svc_rd,
   output logic        svc_oe,
   output logic [15:0] svc_ad,
   input  logic        clr_evnt,
   input  logic        clr_err,
   input  logic        iak_req,
   input  logic [2:0]  iak_pri,
   output logic [3:0]  ia_gnt,
   input  logic        dev_rply,
   input  logic [7:0]  dev_vec,
   output logic        iak_ack,
   output logic [15:0] iak_vec,
   output logic        iak_tmo
);

   // GRANT takes one clock, WAIT runs the rest so the grant lasts TMO_CYC clocks
   localparam logic [7:0] TMO_LOAD = 8'(TMO_CYC - 2);

   logic [5:0]  hi_s;
   logic [4:0]  lo_s;
   logic [3:0]  irq_s;
   logic        evnt_s, halt_s;
   logic        aclo_s, ccerr_s, mmu_s, par_s, dclo_s;

   logic        evnt_prev_q, par_prev_q;
   logic        evnt_rise, par_fall;
   logic        evnt_l_q, par_l_q, bto_l_q;

   logic        svc_oe_q;
   logic [15:0] svc_ad_q, svc_word;

   svc_state_e  state_q, state_d;
   logic [3:0]  win_q, win_d, win_c;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  gnt_q, gnt_d;
   logic        ack_q, ack_d;
   logic [15:0] vec_q, vec_d;
   logic        tmo_q, tmo_d;
   logic        bto_set;

   // Active-high inputs idle low
   f11_svc_sync #(.W(6), .STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_hi (
      .clk   (pin_clk),
      .rst_n (pin_rst_n),
      .d_i   ({halt, evnt, irq}),
      .q_o   (hi_s)
   );

   // Active-low inputs idle high
   f11_svc_sync #(.W(5), .STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_lo (
      .clk   (pin_clk),
      .rst_n (pin_rst_n),
      .d_i   ({dclo_n, par_n, mmu_n, ccerr_n, aclo_n}),
      .q_o   (lo_s)
   );

   assign irq_s   = hi_s[3:0];
   assign evnt_s  = hi_s[4];
   assign halt_s  = hi_s[5];
   assign aclo_s  = lo_s[0];
   assign ccerr_s = lo_s[1];
   assign mmu_s   = lo_s[2];
   assign par_s   = lo_s[3];
   assign dclo_s  = lo_s[4];

   assign evnt_rise = evnt_s & ~evnt_prev_q;
   assign par_fall  = ~par_s & par_prev_q;

   // Edge history and sticky flags; a set always beats a coincident clear
   always_ff @(posedge pin_clk or negedge pin_rst_n) begin
      if (!pin_rst_n) begin
         evnt_prev_q <= 1'b0;
         par_prev_q  <= 1'b1;
         evnt_l_q    <= 1'b0;
         par_l_q     <= 1'b0;
         bto_l_q     <= 1'b0;
      end else begin
         evnt_prev_q <= evnt_s;
         par_prev_q  <= par_s;
         if (evnt_rise)     evnt_l_q <= 1'b1;
         else if (clr_evnt) evnt_l_q <= 1'b0;
         if (par_fall)      par_l_q  <= 1'b1;
         else if (clr_err)  par_l_q  <= 1'b0;
         if (bto_set)       bto_l_q  <= 1'b1;
         else if (clr_err)  bto_l_q  <= 1'b0;
      end
   end

   // Assemble the service word from synchronized sources
   always_comb begin
      svc_word            = 16'h0000;
      svc_word[SVC_EVNT]  = evnt_l_q;
      svc_word[SVC_IRQ4]  = irq_s[0];
      svc_word[SVC_IRQ5]  = irq_s[1];
      svc_word[SVC_IRQ6]  = irq_s[2];
      svc_word[SVC_IRQ7]  = irq_s[3];
      svc_word[SVC_ACLO]  = aclo_s;
      svc_word[SVC_HALT]  = halt_s;
      svc_word[SVC_CCERR] = ccerr_s;
      svc_word[SVC_MMU]   = mmu_s;
      svc_word[SVC_PAR]   = ~par_l_q;
      svc_word[SVC_BTO]   = bto_l_q;
      svc_word[SVC_DCLO]  = dclo_s;
   end

   // Service word capture; AD keeps its last value after the drive window
   always_ff @(posedge pin_clk or negedge pin_rst_n) begin
      if (!pin_rst_n) begin
         svc_oe_q <= 1'b0;
         svc_ad_q <= 16'h0000;
      end else begin
         svc_oe_q <= svc_rd;
         if (svc_rd) svc_ad_q <= svc_word;
      end
   end

   assign win_c = pick_winner(irq_s, iak_pri);

   // Acknowledge handshake next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      tmo_d   = tmo_q;
      bto_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iak_req && (win_c != 4'b0000)) begin
               state_d = ST_GRANT;
               win_d   = win_c;
               cnt_d   = TMO_LOAD;
            end
         end
         ST_GRANT: state_d = ST_WAIT;
         ST_WAIT: begin
            if (dev_rply) begin
               vec_d   = {6'b000000, dev_vec, 2'b00};
               tmo_d   = 1'b0;
               state_d = ST_ACK;
            end else if (cnt_q == 8'd0) begin
               vec_d   = 16'h0000;
               tmo_d   = 1'b1;
               bto_set = 1'b1;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      gnt_d = ((state_d == ST_GRANT) || (state_d == ST_WAIT)) ? win_d : 4'b0000;
      ack_d = (state_d == ST_ACK);
   end

   // Handshake state and output registers
   always_ff @(posedge pin_clk or negedge pin_rst_n) begin
      if (!pin_rst_n) begin
         state_q <= ST_IDLE;
         win_q   <= 4'b0000;
         cnt_q   <= 8'd0;
         gnt_q   <= 4'b0000;
         ack_q   <= 1'b0;
         vec_q   <= 16'h0000;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         vec_q   <= vec_d;
         tmo_q   <= tmo_d;
      end
   end

   assign svc_oe  = svc_oe_q;
   assign svc_ad  = svc_ad_q;
   assign ia_gnt  = gnt_q;
   assign iak_ack = ack_q;
   assign iak_vec = vec_q;
   assign iak_tmo = tmo_q;

endmodule
